// File: rtl/multicycle_cu.sv
// Multi-cycle control unit for the RV32I core: steps each instruction through
// fetch, decode, execute, memory and write-back, with an optional multiply wait path.
module multicycle_cu #(
    parameter bit          ENABLE_M    = 1'b0,
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       funct7_0,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_req,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic [1:0] mem_out_sel,
    output logic       branch,
    output logic       jump,
    output logic       reg_write,
    output logic       illegal,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXEC    = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        MULWAIT = 3'd5,
        TRAP    = 3'd6,
        RST     = 3'd7
    } state_e;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [3:0] MUL_INIT = 4'(MUL_LATENCY - 1);

    state_e     state_q, state_d;
    logic [6:0] op_q, op_d;
    logic       mul_q, mul_d;
    logic [3:0] cnt_q, cnt_d;

    logic       legal;
    logic [1:0] ctl_alu_op;
    logic       ctl_alu_src;
    logic [1:0] ctl_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST;
            op_q    <= '0;
            mul_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            mul_q   <= mul_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_IMM,
            OP_REG, OP_LW, OP_SW, OP_BR: legal = 1'b1;
            default:                     legal = 1'b0;
        endcase
    end

    // Datapath controls held steady for the whole execute/memory/write-back span.
    always_comb begin
        ctl_alu_op  = 2'b00;
        ctl_alu_src = 1'b0;
        ctl_sel     = 2'b00;
        case (op_q)
            OP_LUI:   begin ctl_alu_op = 2'b00; ctl_alu_src = 1'b1; ctl_sel = 2'b01; end
            OP_AUIPC: begin ctl_alu_op = 2'b00; ctl_alu_src = 1'b0; ctl_sel = 2'b10; end
            OP_IMM:   begin ctl_alu_op = 2'b11; ctl_alu_src = 1'b1; ctl_sel = 2'b01; end
            OP_REG:   begin ctl_alu_op = 2'b11; ctl_alu_src = 1'b0; ctl_sel = 2'b01; end
            OP_LW:    begin ctl_alu_op = 2'b10; ctl_alu_src = 1'b1; ctl_sel = 2'b00; end
            OP_SW:    begin ctl_alu_op = 2'b10; ctl_alu_src = 1'b1; ctl_sel = 2'b00; end
            OP_BR:    begin ctl_alu_op = 2'b01; ctl_alu_src = 1'b0; ctl_sel = 2'b00; end
            OP_JAL:   begin ctl_alu_op = 2'b00; ctl_alu_src = 1'b0; ctl_sel = 2'b11; end
            default:  ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mul_d       = mul_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_req     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        alu_op      = 2'b00;
        alu_src     = 1'b0;
        mem_out_sel = 2'b00;
        branch      = 1'b0;
        jump        = 1'b0;
        reg_write   = 1'b0;
        illegal     = 1'b0;

        if (state_q == EXEC || state_q == MEM || state_q == MULWAIT || state_q == WB) begin
            alu_op      = ctl_alu_op;
            alu_src     = ctl_alu_src;
            mem_out_sel = ctl_sel;
        end

        case (state_q)
            RST: state_d = FETCH;
            FETCH: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            // Opcode and the multiply select are captured only here, so later IR changes are harmless.
            DECODE: begin
                op_d    = opcode;
                mul_d   = ENABLE_M && (opcode == OP_REG) && funct7_0;
                state_d = legal ? EXEC : TRAP;
            end
            EXEC: begin
                case (op_q)
                    OP_BR: begin
                        branch  = 1'b1;
                        state_d = FETCH;
                    end
                    OP_JAL: begin
                        jump      = 1'b1;
                        reg_write = 1'b1;
                        state_d   = FETCH;
                    end
                    OP_LW, OP_SW: state_d = MEM;
                    default: begin
                        if (op_q == OP_REG && mul_q) begin
                            cnt_d   = MUL_INIT;
                            state_d = MULWAIT;
                        end else begin
                            state_d = WB;
                        end
                    end
                endcase
            end
            MEM: begin
                mem_req = 1'b1;
                if (op_q == OP_SW) mem_write = 1'b1;
                else               mem_read  = 1'b1;
                if (mem_ready) state_d = (op_q == OP_SW) ? FETCH : WB;
            end
            MULWAIT: begin
                if (cnt_q == 4'd0) state_d = WB;
                else               cnt_d   = cnt_q - 4'd1;
            end
            WB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            TRAP:    illegal = 1'b1;
            default: state_d = RST;
        endcase
    end

    assign state = state_q;

endmodule

// File: doc/multicycle_cu.md
# multicycle_cu

Multi-cycle control unit for the RV32I core: a Moore/Mealy FSM that sequences each instruction through fetch, decode, execute, memory and write-back, replacing the single-cycle opcode decoder. It waits on a memory-ready handshake and optionally supports a fixed-latency multiply path (M extension) through a parametrised wait counter. It sits between the instruction register and the datapath muxes, ALU control, register file and memory interface.

## Interface

- ENABLE_M, 0: 1 = R-format with funct7_0=1 is routed through MULWAIT; 0 = treated as plain R-format.
- MUL_LATENCY, 4: multiply wait cycles (1..15); counter width 4 bits.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- opcode  in  7  instruction[6:0] from the IR.
- funct7_0  in  1  instruction[25], M-extension select.
- mem_ready  in  1  memory completes current request this cycle.
- pc_write  out  1  PC load strobe (PC+4 in FETCH).
- ir_write  out  1  IR load strobe.
- mem_req  out  1  memory request valid.
- mem_read  out  1  read qualifier.
- mem_write  out  1  write qualifier.
- alu_op  out  2  00 nop, 01 sub, 10 add, 11 decode funct.
- alu_src  out  1  1 = immediate operand.
- mem_out_sel  out  2  write-back select: 00 mem, 01 ALU, 10 PC+imm, 11 PC+4.
- branch  out  1  datapath evaluates branch and conditionally loads PC.
- jump  out  1  unconditional PC load (JAL).
- reg_write  out  1  register file write enable.
- illegal  out  1  sticky unsupported-opcode flag.
- state  out  3  current state, for debug.

## Operation

- States: RST(7), FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4), MULWAIT(5), TRAP(6).
- RST: entered asynchronously on rst_n=0; all outputs 0, op_q=0, counter=0, illegal=0; one cycle after release -> FETCH.
- FETCH: mem_req=1, mem_read=1; stay while mem_ready=0; when mem_ready=1, ir_write=1 and pc_write=1 that cycle (Mealy), -> DECODE.
- DECODE: latch opcode into op_q; supported opcodes {0110111, 0010111, 1101111, 0010011, 0110011, 0000011, 0100011, 1100011} -> EXEC, else -> TRAP.
- EXEC, MEM, WB hold per-op_q controls: LUI alu_op 00/src 1/sel 01; AUIPC 00/0/10; I-fmt 11/1/01; R-fmt 11/0/01; LW 10/1/00; SW 10/1/--; BR 01/0; JAL sel 11.
- EXEC exits: BR: branch=1 -> FETCH. JAL: jump=1, reg_write=1 -> FETCH. LW/SW -> MEM. R-fmt with ENABLE_M=1 and funct7_0=1 (sampled in DECODE): load counter MUL_LATENCY-1 -> MULWAIT. All others -> WB.
- MEM: mem_req=1, mem_read=1 (LW) or mem_write=1 (SW); stay while mem_ready=0; on mem_ready: SW -> FETCH, LW -> WB.
- MULWAIT: counter decrements each cycle; at counter=0 -> WB.
- WB: reg_write=1 for exactly one cycle -> FETCH.
- TRAP: illegal=1, all other outputs 0, terminal until reset.
- reg_write, pc_write, ir_write, branch, jump never asserted in two consecutive cycles for one instruction.

## Timing

- Zero-wait cycle counts (FETCH through last state): BR 3, JAL 3, SW 4, LUI/AUIPC/I/R 4, LW 5, MUL 4+MUL_LATENCY.
- Each mem_ready=0 cycle in FETCH/MEM adds one cycle; mem_ready ignored in other states.
- mem_req held high, controls stable, until mem_ready=1 is seen.
- Reset mid-instruction: outputs 0 immediately (asynchronous), pending write/request abandoned; restart at FETCH.
- opcode only sampled in DECODE; IR changes afterwards have no effect.

## Test plan

- Reset then R-fmt 0110011, mem_ready=1 always -> states 7,0,1,2,4,0; reg_write=1 only in WB; alu_op=11, mem_out_sel=01.
- LW with mem_ready low 2 cycles in FETCH and 3 in MEM -> 10 cycles FETCH-to-WB end; mem_req held; reg_write single pulse, mem_out_sel=00.
- SW then BR 1100011 -> SW: mem_write=1 in MEM, no reg_write; BR: branch=1 in EXEC, 3 cycles total.
- ENABLE_M=1, MUL_LATENCY=4, R-fmt funct7_0=1 -> exactly 4 MULWAIT cycles then WB; ENABLE_M=0 same instruction -> no MULWAIT.
- Opcode 1110011 -> TRAP after DECODE, illegal=1 held, no strobes; rst_n low -> illegal=0, state=RST.
- rst_n pulsed low during MEM of SW -> mem_write drops same cycle; FETCH restarts one cycle after release.
